// File: rtl/bram_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_sweep_pkg
// Brief    : Shared types and pattern/signature helpers for the BRAM sweep tester.
// Revision : 1.0
// ============================================================================
package bram_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic MODE_VERIFY = 1'b0;
    localparam logic MODE_SIG    = 1'b1;

    // Operands are widened to 64 bits so one function serves any WID; callers cast back.
    function automatic logic [63:0] exp_pattern(input logic [63:0] addr, input logic [63:0] seed);
        return addr ^ seed;
    endfunction

    function automatic logic [63:0] sig_step(input logic [63:0] sig, input logic [63:0] data,
                                             input int unsigned wid);
        logic [63:0] mask;
        mask = (64'd1 << wid) - 64'd1;
        return (((sig << 1) | (sig >> (wid - 1))) & mask) ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/read_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : read_tag_pipe
// Brief    : LAT-deep {valid, addr} delay line aligning read tags with RAM data.
// Revision : 1.0
// ============================================================================
module read_tag_pipe #(
    parameter int AW  = 12,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [LAT-1:0] r_vld;
    logic [AW-1:0]  r_adr [LAT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) r_adr[i] <= '0;
        end else begin
            r_vld[0] <= in_valid;
            r_adr[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_adr[i] <= r_adr[i-1];
            end
        end
    end

    assign out_valid = r_vld[LAT-1];
    assign out_addr  = r_adr[LAT-1];

endmodule
`default_nettype wire

// File: rtl/bram_sweep_tester.sv
`default_nettype none
// ============================================================================
// Module   : bram_sweep_tester
// Brief    : Write/verify and read-signature sweep sequencer for an 18x4096 BRAM.
// Revision : 1.0
// ============================================================================
module bram_sweep_tester
    import bram_sweep_pkg::*;
#(
    parameter int WID      = 18,
    parameter int DEPTH    = 4096,
    parameter int AW       = 12,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WID-1:0]   seed,
    output logic [AW-1:0]    mem_waddr,
    output logic [WID-1:0]   mem_din,
    output logic             mem_we,
    output logic [AW-1:0]    mem_raddr,
    input  logic [WID-1:0]   mem_dout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [AW-1:0]    first_err_addr,
    output logic [WID-1:0]   signature
);

    localparam logic [AW-1:0]    c_LAST_ADDR = AW'(DEPTH - 1);
    localparam int               c_DRAIN_W   = $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    state_t               r_state, w_state_nxt;
    logic                 r_mode;
    logic [WID-1:0]       r_seed;
    logic [AW-1:0]        r_addr;
    logic [c_DRAIN_W-1:0] r_drain;
    logic [CNT_W-1:0]     r_err;
    logic                 r_fev;
    logic [AW-1:0]        r_fea;
    logic [WID-1:0]       r_sig;

    logic                 w_last, w_drain_end;
    logic                 w_pipe_vld;
    logic [AW-1:0]        w_pipe_addr;
    logic [WID-1:0]       w_exp_a, w_exp_p, w_sig_nxt;

    assign w_last      = (r_addr == c_LAST_ADDR);
    assign w_drain_end = (r_drain == c_DRAIN_W'(READ_LAT - 1));
    assign w_exp_a     = WID'(exp_pattern(64'(r_addr), 64'(r_seed)));
    assign w_exp_p     = WID'(exp_pattern(64'(w_pipe_addr), 64'(r_seed)));
    assign w_sig_nxt   = WID'(sig_step(64'(r_sig), 64'(mem_dout), WID));

    read_tag_pipe #(.AW(AW), .LAT(READ_LAT)) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_state == ST_READ),
        .in_addr   (r_addr),
        .out_valid (w_pipe_vld),
        .out_addr  (w_pipe_addr)
    );

    always_comb begin
        w_state_nxt = r_state;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_din     = '0;
        mem_raddr   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = (mode == MODE_SIG) ? ST_READ : ST_WRITE;
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = r_addr;
                mem_din   = w_exp_a;
                busy      = 1'b1;
                if (w_last) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                mem_raddr = r_addr;
                busy      = 1'b1;
                if (w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_drain_end) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_VERIFY;
            r_seed  <= '0;
            r_addr  <= '0;
            r_drain <= '0;
            r_err   <= '0;
            r_fev   <= 1'b0;
            r_fea   <= '0;
            r_sig   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_seed <= seed;
                        r_addr <= '0;
                        r_err  <= '0;
                        r_fev  <= 1'b0;
                        r_fea  <= '0;
                        r_sig  <= '0;
                    end
                end
                ST_WRITE: r_addr <= w_last ? '0 : r_addr + 1'b1;
                ST_READ: begin
                    r_drain <= '0;
                    if (!w_last) r_addr <= r_addr + 1'b1;
                end
                ST_DRAIN: r_drain <= r_drain + 1'b1;
                default: ;
            endcase
            // Tagged read data is judged the cycle it leaves the pipe.
            if (w_pipe_vld) begin
                if (r_mode == MODE_VERIFY) begin
                    if (mem_dout != w_exp_p) begin
                        if (r_err != c_CNT_MAX) r_err <= r_err + 1'b1;
                        if (!r_fev) begin
                            r_fev <= 1'b1;
                            r_fea <= w_pipe_addr;
                        end
                    end
                end else begin
                    r_sig <= w_sig_nxt;
                end
            end
        end
    end

    assign err_count       = r_err;
    assign first_err_valid = r_fev;
    assign first_err_addr  = r_fea;
    assign signature       = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_bram_sweep_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_sweep_tester
// Brief    : Scoreboard bench for bram_sweep_tester against a behavioural BRAM.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bram_sweep_tester;

    localparam int WID = 18, DEPTH = 4096, AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start, mode;
    logic [WID-1:0] seed;
    logic [AW-1:0]  mem_waddr, mem_raddr, first_err_addr;
    logic [WID-1:0] mem_din, mem_dout, signature;
    logic           mem_we, busy, done, first_err_valid;
    logic [15:0]    err_count;

    logic           start8;
    logic [WID-1:0] seed8;
    logic [AW-1:0]  mem_waddr8, mem_raddr8, first_err_addr8;
    logic [WID-1:0] mem_din8, mem_dout8, signature8;
    logic           mem_we8, busy8, done8, first_err_valid8;
    logic [7:0]     err_count8;

    bram_sweep_tester u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we), .mem_raddr(mem_raddr),
        .mem_dout(mem_dout), .busy(busy), .done(done), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr), .signature(signature)
    );

    bram_sweep_tester #(.CNT_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(1'b0), .seed(seed8),
        .mem_waddr(mem_waddr8), .mem_din(mem_din8), .mem_we(mem_we8), .mem_raddr(mem_raddr8),
        .mem_dout(mem_dout8), .busy(busy8), .done(done8), .err_count(err_count8),
        .first_err_valid(first_err_valid8), .first_err_addr(first_err_addr8), .signature(signature8)
    );

    // Behavioural RAM with registered read and optional bit-0 faults at two addresses.
    logic [WID-1:0] ram [DEPTH];
    bit             flip_en = 1'b0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_din;
        mem_dout <= ram[mem_raddr] ^ {{(WID-1){1'b0}},
                    (flip_en && (mem_raddr == 12'h7FF || mem_raddr == 12'h123))};
    end

    // Second RAM always answers with the complement of the pattern word.
    always @(posedge clk) mem_dout8 <= ~(WID'(mem_raddr8) ^ seed8);

    typedef struct {
        int             cycles;
        int             wes;
        int             err;
        bit             fev;
        int             fea;
        logic [WID-1:0] sig;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic launch(input logic m, input logic [WID-1:0] s);
        @(negedge clk);
        mode  = m;
        seed  = s;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Counts edges from the accepting edge to the edge that samples done high.
    task automatic run_to_done(input int p1, input int p2,
                               output int cycles, output int wes, output bit busy0);
        int n;
        n = 0; cycles = -1; wes = 0; busy0 = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (n == 0) busy0 = busy;
            start = (n == p1 || n == p2);
            if (mem_we) wes++;
            if (done) begin
                cycles = n + 1;
                break;
            end
            @(posedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; start8 = 1'b0; seed8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, mem_we, mem_waddr, mem_din, mem_raddr, err_count, first_err_valid,
             first_err_addr, signature} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%b err=%0d sig=%h, want all zero",
                     busy, done, mem_we, err_count, signature);
        end
        reset = 1'b1;
    endtask

    task automatic test_verify(input bit faults, input string name);
        exp_t e;
        int cyc, wes;
        bit b0;
        flip_en = faults;
        sb.push_back('{cycles: 8194, wes: 4096, err: faults ? 2 : 0, fev: faults,
                       fea: faults ? 'h123 : 0, sig: '0});
        launch(1'b0, 18'h15A5A);
        run_to_done(-1, -1, cyc, wes, b0);
        e = sb.pop_front();
        total++;
        if (cyc !== e.cycles) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, e.cycles); end
        total++;
        if (wes !== e.wes) begin bad++; $display("FAIL %s_we_cycles: got %0d want %0d", name, wes, e.wes); end
        total++;
        if (b0 !== 1'b1) begin bad++; $display("FAIL %s_busy_after_start: got %b want 1", name, b0); end
        total++;
        if (int'(err_count) !== e.err) begin bad++; $display("FAIL %s_err_count: got %0d want %0d", name, err_count, e.err); end
        total++;
        if (first_err_valid !== e.fev) begin bad++; $display("FAIL %s_first_valid: got %b want %b", name, first_err_valid, e.fev); end
        total++;
        if (int'(first_err_addr) !== e.fea) begin bad++; $display("FAIL %s_first_addr: got %h want %h", name, first_err_addr, e.fea); end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin bad++; $display("FAIL %s_done_pulse: done=%b busy=%b want 0 0", name, done, busy); end
        flip_en = 1'b0;
    endtask

    task automatic test_reset_results();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({err_count, first_err_valid, first_err_addr, signature} !== '0) begin
            bad++;
            $display("FAIL reset_results: err=%0d fev=%b fea=%h sig=%h want 0", err_count,
                     first_err_valid, first_err_addr, signature);
        end
        reset = 1'b1;
    endtask

    task automatic test_signature(input bit addr_data, input string name);
        exp_t e;
        logic [WID-1:0] g;
        int cyc, wes;
        bit b0;
        g = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ram[a] = addr_data ? WID'(a) : '0;
            g = {g[WID-2:0], g[WID-1]} ^ (addr_data ? WID'(a) : '0);
        end
        sb.push_back('{cycles: 4098, wes: 0, err: 0, fev: 1'b0, fea: 0, sig: g});
        launch(1'b1, 18'h3FFFF);
        run_to_done(-1, -1, cyc, wes, b0);
        e = sb.pop_front();
        total++;
        if (cyc !== e.cycles) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, e.cycles); end
        total++;
        if (wes !== e.wes) begin bad++; $display("FAIL %s_we_cycles: got %0d want %0d", name, wes, e.wes); end
        total++;
        if (signature !== e.sig) begin bad++; $display("FAIL %s_signature: got %h want %h", name, signature, e.sig); end
        total++;
        if (int'(err_count) !== e.err) begin bad++; $display("FAIL %s_err_count: got %0d want %0d", name, err_count, e.err); end
    endtask

    task automatic test_abort();
        exp_t e;
        int cyc, wes, quiet;
        bit b0, hit;
        hit = 1'b0;
        launch(1'b0, 18'h0ABCD);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_we && mem_waddr == 12'd100) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL abort_reach_addr100: got no write at 100 want write at 100"); end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, mem_we, mem_waddr, mem_din, mem_raddr, err_count, first_err_valid,
             first_err_addr, signature} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: busy=%b we=%b waddr=%0d din=%h want all zero",
                     busy, mem_we, mem_waddr, mem_din);
        end
        reset = 1'b1;
        quiet = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) quiet++;
        end
        total++;
        if (quiet !== 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", quiet); end
        sb.push_back('{cycles: 8194, wes: 4096, err: 0, fev: 1'b0, fea: 0, sig: '0});
        launch(1'b0, 18'h0ABCD);
        run_to_done(-1, -1, cyc, wes, b0);
        e = sb.pop_front();
        total++;
        if (cyc !== e.cycles) begin bad++; $display("FAIL abort_rerun_latency: got %0d want %0d", cyc, e.cycles); end
        total++;
        if (int'(err_count) !== e.err) begin bad++; $display("FAIL abort_rerun_err: got %0d want %0d", err_count, e.err); end
    endtask

    task automatic test_back_to_back_start();
        exp_t e;
        int cyc, wes, extra;
        bit b0;
        sb.push_back('{cycles: 8194, wes: 4096, err: 0, fev: 1'b0, fea: 0, sig: '0});
        launch(1'b0, 18'h2C3C3);
        run_to_done(10, 5000, cyc, wes, b0);
        e = sb.pop_front();
        total++;
        if (cyc !== e.cycles) begin bad++; $display("FAIL ignore_start_latency: got %0d want %0d", cyc, e.cycles); end
        total++;
        if (wes !== e.wes) begin bad++; $display("FAIL ignore_start_we: got %0d want %0d", wes, e.wes); end
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ignore_start_no_requeue: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_saturate();
        int n, cyc;
        n = 0; cyc = -1;
        @(negedge clk);
        seed8  = 18'h1F0F0;
        start8 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                cyc = n + 1;
                break;
            end
            @(posedge clk);
            n++;
        end
        total++;
        if (cyc !== 8194) begin bad++; $display("FAIL sat_latency: got %0d want 8194", cyc); end
        total++;
        if (err_count8 !== 8'd255) begin bad++; $display("FAIL sat_err_count: got %0d want 255", err_count8); end
        total++;
        if ({first_err_valid8, first_err_addr8} !== {1'b1, 12'h000}) begin
            bad++;
            $display("FAIL sat_first_err: got valid=%b addr=%h want valid=1 addr=000",
                     first_err_valid8, first_err_addr8);
        end
    endtask

    initial begin
        test_reset();
        test_verify(1'b0, "verify_ideal");
        test_verify(1'b1, "verify_faults");
        test_reset_results();
        test_signature(1'b0, "sig_zero");
        test_signature(1'b1, "sig_addr");
        test_abort();
        test_back_to_back_start();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_sweep_tester.md
Name: bram_sweep_tester

Overview:
- Sequencer that sits directly in front of and behind the 18x4096 block-RAM wrapper. It drives the RAM's waddr/din/write-enable and raddr, and consumes the RAM's registered dout.
- Mode 0: writes a seeded address pattern to every location, then reads it back and counts mismatches.
- Mode 1: read-only sweep that produces a signature of the current contents. Used to confirm that a bitstream memory reinit landed.

Parameters:
- WID, 18, RAM data width.
- DEPTH, 4096, RAM depth; power of two.
- AW, 12, address width; equals log2(DEPTH).
- READ_LAT, 1, cycles from raddr to valid dout; range 1..4.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = write+verify, 1 = signature only; sampled with start.
- seed  in  WID  pattern seed; sampled with start.
- mem_waddr  out  AW  RAM write address.
- mem_din  out  WID  RAM write data.
- mem_we  out  1  RAM write enable; the RAM instance must gate its write with this.
- mem_raddr  out  AW  RAM read address.
- mem_dout  in  WID  RAM read data, valid READ_LAT cycles after mem_raddr.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a sweep.
- err_count  out  CNT_W  saturating mismatch count (mode 0).
- first_err_valid  out  1  at least one mismatch seen.
- first_err_addr  out  AW  address of the first mismatch.
- signature  out  WID  mode-1 result.

Behaviour:
- Reset (reset==0 at a clk edge): FSM goes to IDLE. Every output is 0 and every result register is cleared. Any sweep in progress is aborted with no done pulse.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - When start==1, latch mode and seed, clear all results, and load the address counter with 0.
  - Next state is WRITE if mode==0, otherwise READ.
- WRITE:
  - Each cycle: mem_we=1, mem_waddr=a, mem_din=exp(a); then a increments.
  - exp(a) = zero-extend(a) XOR seed, truncated to WID.
  - After a==DEPTH-1 is written, reset a to 0 and go to READ. This takes DEPTH cycles.
- READ:
  - Each cycle: mem_raddr=a, and {a, valid} is pushed into a READ_LAT-deep delay pipe.
  - mem_we=0 in every state other than WRITE.
  - After a==DEPTH-1 is issued, go to DRAIN.
- DRAIN: stays for exactly READ_LAT cycles, then goes to DONE.
- Pipe output: when a valid entry with address p emerges, mem_dout is checked in that same cycle.
  - Mode 0: if mem_dout != exp(p), increment err_count, saturating at 2^CNT_W-1. On the first mismatch only, set first_err_valid=1 and first_err_addr=p.
  - Mode 1: signature <= rotl1(signature) XOR mem_dout, processed in ascending address order starting from 0.
- DONE: done=1 and busy=0 for one cycle, then IDLE. Results hold until the next accepted start or reset.
- Timing from the start-accepted edge:
  - Mode 0: done is asserted 2*DEPTH+READ_LAT+1 cycles later.
  - Mode 1: done is asserted DEPTH+READ_LAT+1 cycles later.
- start while busy, or in DONE: ignored, with no queuing.
- Address counter: AW bits wide. The terminal condition is compared explicitly, so the counter never relies on wrap-around.
- Same-address read/write collision cannot occur because the phases are disjoint.

Decomposition:
- Package bram_sweep_pkg:
  - state enum type (IDLE/WRITE/READ/DRAIN/DONE).
  - mode constants MODE_VERIFY=0 and MODE_SIG=1.
  - functions exp_pattern(addr, seed) and sig_step(sig, data).
- One sub-module, read_tag_pipe: a parameterised READ_LAT-deep shift register of {valid, addr}, reset to all-invalid.

Test Plan:
- Mode 0, seed=0x15A5A, ideal RAM model -> err_count=0, first_err_valid=0, done pulse exactly 8194 cycles after start is accepted, mem_we high for exactly 4096 cycles.
- Mode 0, RAM model flips bit 0 on reads of 0x7FF and 0x123 -> err_count=2, first_err_addr=0x123 (first in ascending order), first_err_valid=1.
- Mode 1 on all-zero RAM -> signature=0, mem_we never 1, done 4098 cycles after start. Repeat on RAM with data=address -> signature matches the bench golden fold.
- Reset asserted in WRITE at address 100 -> on the next edge all outputs are 0 and no done pulse. A fresh start then runs a complete 8194-cycle sweep.
- CNT_W=8, RAM returns the complement of every expected word -> err_count saturates at 255, first_err_addr=0.
- start pulses at cycles 10 and 5000 within a mode-0 sweep are ignored -> a single done pulse only.
